// File: rtl/scanner_sequencer_if.sv
// scanner_sequencer_if: control and lamp-drive bundle for the Larson scanner sequencer
// master: drives i_run (step enable), i_sync (restart), i_div (step period - 1)
// slave: drives o_leds (lamp drive), o_pos, o_dir, o_tick (step pulse), o_end (bounce pulse)
interface scanner_sequencer_if #(
   parameter int N_LEDS = 8,
   parameter int DIV_W  = 16
);
   localparam int POS_W = $clog2(N_LEDS);
   logic              i_run;
   logic              i_sync;
   logic [DIV_W-1:0]  i_div;
   logic [N_LEDS-1:0] o_leds;
   logic [POS_W-1:0]  o_pos;
   logic              o_dir;
   logic              o_tick;
   logic              o_end;
   modport master (output i_run, i_sync, i_div, input o_leds, o_pos, o_dir, o_tick, o_end);
   modport slave  (input i_run, i_sync, i_div, output o_leds, o_pos, o_dir, o_tick, o_end);
endinterface

// File: rtl/scanner_sequencer.sv
// scanner_sequencer: prescaled position counter bouncing across N_LEDS lamp outputs
// i_clk: clock; i_rst_n: async active-low reset; bus: scanner_sequencer_if.slave
// Macro SCANNER_TRAIL_EN: when defined, o_leds also lights the previous position
module scanner_sequencer #(
   parameter int N_LEDS = 8,
   parameter int DIV_W  = 16
) (
   input logic               i_clk,
   input logic               i_rst_n,
   scanner_sequencer_if.slave bus
);
   localparam int POS_W = $clog2(N_LEDS);
   localparam logic [N_LEDS-1:0] ONE = {{(N_LEDS-1){1'b0}}, 1'b1};
   logic [DIV_W-1:0] cnt;
   logic [POS_W-1:0] pos;
   logic             dir;
   logic             tick;
   logic             end_p;
   logic             step;
   // >= so a lowered divider below the running count steps on the next edge
   assign step = bus.i_run && (cnt >= bus.i_div);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         cnt   <= '0;
         pos   <= '0;
         dir   <= 1'b0;
         tick  <= 1'b0;
         end_p <= 1'b0;
      end else if (bus.i_sync) begin
         cnt   <= '0;
         pos   <= '0;
         dir   <= 1'b0;
         tick  <= 1'b0;
         end_p <= 1'b0;
      end else if (!bus.i_run) begin
         tick  <= 1'b0;
         end_p <= 1'b0;
      end else if (step) begin
         cnt   <= '0;
         pos   <= dir ? pos - 1'b1 : pos + 1'b1;
         // turn around when the step lands on either end
         dir   <= dir ? (pos != POS_W'(1)) : (pos == POS_W'(N_LEDS - 2));
         end_p <= dir ? (pos == POS_W'(1)) : (pos == POS_W'(N_LEDS - 2));
         tick  <= 1'b1;
      end else begin
         cnt   <= cnt + 1'b1;
         tick  <= 1'b0;
         end_p <= 1'b0;
      end
`ifdef SCANNER_TRAIL_EN
   logic [POS_W-1:0] prev;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         prev <= '0;
      else if (bus.i_sync)
         prev <= '0;
      else if (step)
         prev <= pos;
   assign bus.o_leds = (ONE << pos) | (ONE << prev);
`else
   assign bus.o_leds = ONE << pos;
`endif
   assign bus.o_pos  = pos;
   assign bus.o_dir  = dir;
   assign bus.o_tick = tick;
   assign bus.o_end  = end_p;
endmodule
